// File: rtl/gemm_sched.sv
// gemm_sched: instruction scheduler in front of the GEMM pipeline core.
// Accepts one 128-bit instruction at a time, replays it to the core for
// iter_out*iter_in*(uop_end-uop_bgn) cycles, then lets the back end drain
// for PIPE_DEPTH cycles before pulsing done.
// Optional build macro: GEMM_SCHED_PERF_EN adds the perf_cycles counter.
module gemm_sched #(
   parameter int INS_WIDTH  = 128,
   parameter int UPC_WIDTH  = 13,
   parameter int LOOP_WIDTH = 14,
   parameter int PIPE_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 insn_valid,
   output logic                 insn_ready,
   input  logic [INS_WIDTH-1:0] insn_in,
   output logic [INS_WIDTH-1:0] core_insn,
   output logic                 core_start,
   output logic                 busy,
   output logic                 done,
   output logic [UPC_WIDTH-1:0] uop_idx,
   output logic                 err_opcode
`ifdef GEMM_SCHED_PERF_EN
   ,
   output logic [31:0]          perf_cycles
`endif
);

   localparam logic [2:0] OP_GEMM = 3'b010;
   localparam int BGN_LSB  = 8;
   localparam int END_LSB  = BGN_LSB + UPC_WIDTH;
   localparam int OUT_LSB  = END_LSB + LOOP_WIDTH;
   localparam int IN_LSB   = OUT_LSB + LOOP_WIDTH;
   localparam int DRW      = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
   localparam logic [DRW-1:0]        DRAIN_LOAD = DRW'(PIPE_DEPTH - 1);
   localparam logic [DRW-1:0]        DRAIN_ONE  = DRW'(1);
   localparam logic [LOOP_WIDTH-1:0] LOOP_ONE   = LOOP_WIDTH'(1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t                state_q, state_d;
   logic [INS_WIDTH-1:0]  insn_q;
   logic [LOOP_WIDTH-1:0] u_q, i_q, o_q;
   logic [DRW-1:0]        drain_q;
   logic                  first_q;

   // Fields of the incoming instruction (used only at acceptance)
   logic [UPC_WIDTH-1:0]  in_bgn;
   logic [LOOP_WIDTH-1:0] in_end, in_out, in_in;
   // Fields of the latched instruction (loop bounds while running)
   logic [UPC_WIDTH-1:0]  q_bgn;
   logic [LOOP_WIDTH-1:0] q_end, q_out, q_in;
   logic                  in_bad, in_empty, accept;
   logic                  u_wrap, i_wrap, o_last, run_last;

   assign in_bgn = insn_in[BGN_LSB +: UPC_WIDTH];
   assign in_end = insn_in[END_LSB +: LOOP_WIDTH];
   assign in_out = insn_in[OUT_LSB +: LOOP_WIDTH];
   assign in_in  = insn_in[IN_LSB  +: LOOP_WIDTH];
   assign q_bgn  = insn_q[BGN_LSB +: UPC_WIDTH];
   assign q_end  = insn_q[END_LSB +: LOOP_WIDTH];
   assign q_out  = insn_q[OUT_LSB +: LOOP_WIDTH];
   assign q_in   = insn_q[IN_LSB  +: LOOP_WIDTH];

   assign in_bad   = (insn_in[2:0] != OP_GEMM);
   assign in_empty = (in_out == '0) || (in_in == '0) || (in_end <= LOOP_WIDTH'(in_bgn));
   // Gating with rst keeps insn_ready low while reset is held
   assign accept   = (state_q == IDLE) && rst && insn_valid;

   // Bounds are compared against the latched limits, so counters never wrap
   assign u_wrap   = (u_q == q_end - LOOP_ONE);
   assign i_wrap   = (i_q == q_in - LOOP_ONE);
   assign o_last   = (o_q == q_out - LOOP_ONE);
   assign run_last = u_wrap && i_wrap && o_last;

   assign uop_idx  = u_q[UPC_WIDTH-1:0];

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // Next-state and core-facing outputs; the core sees a NOP outside RUN/DRAIN
   always_comb begin
      state_d    = state_q;
      insn_ready = 1'b0;
      core_insn  = '0;
      core_start = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state_q)
         IDLE: begin
            insn_ready = rst;
            if (accept) state_d = (in_bad || in_empty) ? DONE : RUN;
         end
         RUN: begin
            core_insn  = insn_q;
            core_start = first_q;
            busy       = 1'b1;
            if (run_last) state_d = DRAIN;
         end
         DRAIN: begin
            // Opcode cleared so the core tags no further writes
            core_insn = {insn_q[INS_WIDTH-1:3], 3'b000};
            busy      = 1'b1;
            if (drain_q == '0) state_d = DONE;
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Latch the accepted instruction; held stable until the next acceptance
   always_ff @(posedge clk) begin
      if (accept) insn_q <= insn_in;
   end

   // Loop-nest counters (u innermost), drain countdown, start flag, sticky error
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         u_q        <= '0;
         i_q        <= '0;
         o_q        <= '0;
         drain_q    <= '0;
         first_q    <= 1'b0;
         err_opcode <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  u_q     <= LOOP_WIDTH'(in_bgn);
                  i_q     <= '0;
                  o_q     <= '0;
                  first_q <= !(in_bad || in_empty);
                  if (in_bad) err_opcode <= 1'b1;
               end
            end
            RUN: begin
               first_q <= 1'b0;
               if (u_wrap) begin
                  u_q <= LOOP_WIDTH'(q_bgn);
                  if (i_wrap) begin
                     i_q <= '0;
                     o_q <= o_q + LOOP_ONE;
                  end else begin
                     i_q <= i_q + LOOP_ONE;
                  end
               end else begin
                  u_q <= u_q + LOOP_ONE;
               end
               if (run_last) drain_q <= DRAIN_LOAD;
            end
            DRAIN: begin
               if (drain_q != '0) drain_q <= drain_q - DRAIN_ONE;
            end
            default: ;
         endcase
      end
   end

`ifdef GEMM_SCHED_PERF_EN
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   // Cycles in RUN+DRAIN for the latest instruction; frozen once done
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                    perf_cycles <= '0;
      else if (accept)                             perf_cycles <= '0;
      else if (state_q == RUN || state_q == DRAIN) perf_cycles <= sat_inc(perf_cycles);
   end
`endif

endmodule

// File: tb/tb_gemm_sched.sv
// tb_gemm_sched: self-checking bench for gemm_sched with a cycle-indexed
// reference model derived from the loop-nest arithmetic.
module tb_gemm_sched;

   localparam int P    = 4;
   localparam int MAXC = 256;

   logic         clk = 1'b0;
   logic         rst;
   logic         insn_valid;
   logic         insn_ready;
   logic [127:0] insn_in;
   logic [127:0] core_insn;
   logic         core_start;
   logic         busy;
   logic         done;
   logic [12:0]  uop_idx;
   logic         err_opcode;
`ifdef GEMM_SCHED_PERF_EN
   logic [31:0]  perf_cycles;
`endif

   int checks   = 0;
   int failures = 0;

   gemm_sched dut (
      .clk        (clk),
      .rst        (rst),
      .insn_valid (insn_valid),
      .insn_ready (insn_ready),
      .insn_in    (insn_in),
      .core_insn  (core_insn),
      .core_start (core_start),
      .busy       (busy),
      .done       (done),
      .uop_idx    (uop_idx),
      .err_opcode (err_opcode)
`ifdef GEMM_SCHED_PERF_EN
      ,
      .perf_cycles(perf_cycles)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [127:0] core;
      logic         busy;
      logic         start;
      logic         done;
      logic         ready;
      logic [12:0]  uop;
   } snap_t;

   snap_t obs   [MAXC];
   snap_t exp_s [MAXC];
   bit    uv    [MAXC];

   function automatic logic [127:0] mk(input logic [2:0] op, input int b, input int e,
                                       input int io, input int ii);
      logic [127:0] r;
      r = {$urandom, $urandom, $urandom, $urandom};
      r[2:0]   = op;
      r[20:8]  = 13'(b);
      r[34:21] = 14'(e);
      r[48:35] = 14'(io);
      r[62:49] = 14'(ii);
      return r;
   endfunction

   // Idle expectation everywhere: NOP, ready, nothing pulsing
   task automatic model_clear();
      for (int c = 0; c < MAXC; c++) begin
         exp_s[c] = '{core: '0, busy: 1'b0, start: 1'b0, done: 1'b0, ready: 1'b1, uop: '0};
         uv[c]    = 1'b0;
      end
   endtask

   // Expected behaviour of one instruction accepted on the edge before cycle 'base'
   task automatic model_add(input logic [127:0] ins, input int base, output int done_at);
      int b, e, io, ii, len, n;
      logic [127:0] dr;
      b = int'(ins[20:8]); e = int'(ins[34:21]); io = int'(ins[48:35]); ii = int'(ins[62:49]);
      if (ins[2:0] != 3'b010 || io == 0 || ii == 0 || e <= b) begin
         done_at = base;
      end else begin
         len = e - b;
         n   = io * ii * len;
         dr  = ins;
         dr[2:0] = 3'b000;
         for (int c = 0; c < n; c++) begin
            exp_s[base+c].core  = ins;
            exp_s[base+c].busy  = 1'b1;
            exp_s[base+c].ready = 1'b0;
            exp_s[base+c].start = (c == 0);
            exp_s[base+c].uop   = 13'(b + c % len);
            uv[base+c]          = 1'b1;
         end
         for (int k = 0; k < P; k++) begin
            exp_s[base+n+k].core  = dr;
            exp_s[base+n+k].busy  = 1'b1;
            exp_s[base+n+k].ready = 1'b0;
         end
         done_at = base + n + P;
      end
      exp_s[done_at].done  = 1'b1;
      exp_s[done_at].ready = 1'b0;
   endtask

   // Present an instruction and return once it will be taken on the next edge
   task automatic send(input logic [127:0] ins, output bit ok);
      @(negedge clk);
      insn_in    = ins;
      insn_valid = 1'b1;
      ok         = 1'b0;
      for (int k = 0; k < 64; k++) begin
         if (insn_ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   // Record n cycles after acceptance; swap in 'nxt' at cycle 0, drop valid at drop_at
   task automatic collect(input int n, input logic [127:0] nxt, input int drop_at);
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         obs[c] = '{core: core_insn, busy: busy, start: core_start, done: done,
                    ready: insn_ready, uop: uop_idx};
         if (c == 0) insn_in = nxt;
         if (c == drop_at) insn_valid = 1'b0;
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++;
      if ({core_insn, busy, core_start, done, insn_ready, uop_idx, err_opcode} !== '0) begin
         failures++;
         $display("FAIL reset_state got core=%h busy=%b start=%b done=%b ready=%b uop=%0d err=%b want all zero",
                  core_insn, busy, core_start, done, insn_ready, uop_idx, err_opcode);
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (insn_ready !== 1'b1 || core_insn !== '0) begin
         failures++;
         $display("FAIL reset_release got ready=%b core=%h want ready=1 core=0", insn_ready, core_insn);
      end
   endtask

   task automatic test_single();
      logic [127:0] ins;
      int d;
      bit ok;
      ins = mk(3'b010, 0, 4, 2, 3);
      model_clear();
      model_add(ins, 0, d);
      send(ins, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL single_accept got=timeout want=ready"); end
      collect(d + 3, ins, 0);
      for (int c = 0; c < d + 3; c++) begin
         snap_t o;
         o = obs[c];
         if (!uv[c]) o.uop = '0;
         checks++;
         if (o !== exp_s[c]) begin
            failures++;
            $display("FAIL single cyc=%0d got=%h want=%h", c, o, exp_s[c]);
         end
      end
   endtask

   task automatic test_empty_nest();
      logic [127:0] ins;
      int d;
      bit ok;
      ins = mk(3'b010, 5, 9, 2, 0);
      model_clear();
      model_add(ins, 0, d);
      send(ins, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL empty_accept got=timeout want=ready"); end
      collect(d + 4, ins, 0);
      for (int c = 0; c < d + 4; c++) begin
         snap_t o;
         o = obs[c];
         if (!uv[c]) o.uop = '0;
         checks++;
         if (o !== exp_s[c]) begin
            failures++;
            $display("FAIL empty cyc=%0d got=%h want=%h", c, o, exp_s[c]);
         end
      end
`ifdef GEMM_SCHED_PERF_EN
      checks++;
      if (perf_cycles !== 32'd0) begin
         failures++;
         $display("FAIL empty_perf got=%0d want=0", perf_cycles);
      end
`endif
   endtask

   task automatic test_back_to_back();
      logic [127:0] a, b;
      int da, db;
      bit ok;
      a = mk(3'b010, 100, 101, 1, 1);
      b = mk(3'b010, 7, 8, 1, 1);
      model_clear();
      model_add(a, 0, da);
      model_add(b, da + 2, db);
      send(a, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL b2b_accept got=timeout want=ready"); end
      collect(db + 3, b, da + 2);
      for (int c = 0; c < db + 3; c++) begin
         snap_t o;
         o = obs[c];
         if (!uv[c]) o.uop = '0;
         checks++;
         if (o !== exp_s[c]) begin
            failures++;
            $display("FAIL b2b cyc=%0d got=%h want=%h", c, o, exp_s[c]);
         end
      end
   endtask

   task automatic test_random();
      logic [127:0] ins;
      int d, b;
      bit ok;
      for (int t = 0; t < 8; t++) begin
         b   = $urandom_range(0, 8000);
         ins = mk(3'b010, b, b + $urandom_range(0, 3), $urandom_range(1, 3), $urandom_range(0, 3));
         model_clear();
         model_add(ins, 0, d);
         send(ins, ok);
         checks++;
         if (!ok) begin failures++; $display("FAIL rand_accept t=%0d got=timeout want=ready", t); end
         collect(d + 3, ins, 0);
         for (int c = 0; c < d + 3; c++) begin
            snap_t o;
            o = obs[c];
            if (!uv[c]) o.uop = '0;
            checks++;
            if (o !== exp_s[c]) begin
               failures++;
               $display("FAIL rand t=%0d cyc=%0d got=%h want=%h", t, c, o, exp_s[c]);
            end
         end
      end
      checks++;
      if (err_opcode !== 1'b0) begin
         failures++;
         $display("FAIL rand_err got=%b want=0", err_opcode);
      end
   endtask

   task automatic test_bad_opcode();
      logic [127:0] ins;
      int d;
      bit ok;
      ins = mk(3'b011, 2, 6, 2, 2);
      model_clear();
      model_add(ins, 0, d);
      send(ins, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL badop_accept got=timeout want=ready"); end
      collect(d + 3, ins, 0);
      for (int c = 0; c < d + 3; c++) begin
         snap_t o;
         o = obs[c];
         if (!uv[c]) o.uop = '0;
         checks++;
         if (o !== exp_s[c]) begin
            failures++;
            $display("FAIL badop cyc=%0d got=%h want=%h", c, o, exp_s[c]);
         end
      end
      checks++;
      if (err_opcode !== 1'b1) begin failures++; $display("FAIL badop_err got=%b want=1", err_opcode); end
      ins = mk(3'b010, 3, 5, 1, 2);
      model_clear();
      model_add(ins, 0, d);
      send(ins, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL badop_next_accept got=timeout want=ready"); end
      collect(d + 3, ins, 0);
      for (int c = 0; c < d + 3; c++) begin
         snap_t o;
         o = obs[c];
         if (!uv[c]) o.uop = '0;
         checks++;
         if (o !== exp_s[c]) begin
            failures++;
            $display("FAIL badop_next cyc=%0d got=%h want=%h", c, o, exp_s[c]);
         end
      end
      checks++;
      if (err_opcode !== 1'b1) begin failures++; $display("FAIL badop_sticky got=%b want=1", err_opcode); end
   endtask

   task automatic test_reset_mid_run();
      logic [127:0] ins;
      int d;
      bit ok;
      ins = mk(3'b010, 10, 12, 2, 2);
      send(ins, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL rstrun_accept got=timeout want=ready"); end
      @(negedge clk);
      insn_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || core_insn !== ins) begin
         failures++;
         $display("FAIL rstrun_running got busy=%b core=%h want busy=1 core=%h", busy, core_insn, ins);
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({core_insn, busy, core_start, done, insn_ready, uop_idx, err_opcode} !== '0) begin
         failures++;
         $display("FAIL rstrun_async got core=%h busy=%b start=%b done=%b ready=%b uop=%0d err=%b want all zero",
                  core_insn, busy, core_start, done, insn_ready, uop_idx, err_opcode);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (insn_ready !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL rstrun_release got ready=%b done=%b busy=%b want 1 0 0", insn_ready, done, busy);
      end
      ins = mk(3'b010, 20, 23, 2, 1);
      model_clear();
      model_add(ins, 0, d);
      send(ins, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL rstrun_next_accept got=timeout want=ready"); end
      collect(d + 3, ins, 0);
      for (int c = 0; c < d + 3; c++) begin
         snap_t o;
         o = obs[c];
         if (!uv[c]) o.uop = '0;
         checks++;
         if (o !== exp_s[c]) begin
            failures++;
            $display("FAIL rstrun_next cyc=%0d got=%h want=%h", c, o, exp_s[c]);
         end
      end
   endtask

   task automatic test_max_bounds();
      logic [127:0] ins;
      int d;
      bit ok;
      ins = mk(3'b010, 8190, 8192, 1, 3);
      model_clear();
      model_add(ins, 0, d);
      send(ins, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL max_accept got=timeout want=ready"); end
      collect(d + 3, ins, 0);
      for (int c = 0; c < d + 3; c++) begin
         snap_t o;
         o = obs[c];
         if (!uv[c]) o.uop = '0;
         checks++;
         if (o !== exp_s[c]) begin
            failures++;
            $display("FAIL max cyc=%0d got=%h want=%h", c, o, exp_s[c]);
         end
      end
`ifdef GEMM_SCHED_PERF_EN
      checks++;
      if (perf_cycles !== 32'd10) begin
         failures++;
         $display("FAIL max_perf got=%0d want=10", perf_cycles);
      end
`endif
   endtask

   initial begin
      rst        = 1'b0;
      insn_valid = 1'b0;
      insn_in    = '0;
      test_reset();
      test_single();
      test_empty_nest();
      test_back_to_back();
      test_random();
      test_bad_opcode();
      test_reset_mid_run();
      test_max_bounds();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/gemm_sched.md
Name: gemm_sched

Overview:
- Instruction scheduler in front of the GEMM pipeline core.
- Accepts 128-bit GEMM instructions over a valid/ready handshake and presents each one to the core (insn bus) for exactly the number of cycles its loop nest needs.
- Waits for the 4-stage back end (U2I, I2M, M2E, E2W) to drain, then pulses done. Between instructions the core sees an all-zero (NOP) instruction, so acc/out write enables stay low.

Parameters:
- INS_WIDTH, 128, instruction width
- UPC_WIDTH, 13, uop index width (uop_bgn)
- LOOP_WIDTH, 14, width of uop_end, iter_out and iter_in fields
- PIPE_DEPTH, 4, cycles from the last uop issue to the last write-back

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- insn_valid  in  1  upstream instruction valid
- insn_ready  out  1  scheduler can accept an instruction
- insn_in  in  INS_WIDTH  upstream instruction
- core_insn  out  INS_WIDTH  instruction driven to the GEMM core
- core_start  out  1  one-cycle pulse on the first issue cycle of an instruction
- busy  out  1  instruction in flight (RUN or DRAIN)
- done  out  1  one-cycle pulse on instruction completion
- uop_idx  out  UPC_WIDTH  current uop index (debug/monitor)
- err_opcode  out  1  sticky: non-GEMM opcode was accepted

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; core_insn=0; insn_ready=0; core_start=0; busy=0; done=0; uop_idx=0; err_opcode=0.
  - All counters cleared. Takes effect mid-instruction: the core immediately sees a NOP and no done pulse is produced.
- Field decode (of the latched instruction):
  - opcode = [2:0], GEMM = 3'b010
  - reset flag = [7]
  - uop_bgn = [20:8]
  - uop_end = [34:21]
  - iter_out = [48:35]
  - iter_in = [62:49]
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - insn_ready=1; core_insn=0.
  - On insn_valid&&insn_ready, latch insn_in.
  - Empty loop nest (iter_out==0, iter_in==0, or uop_end<=uop_bgn) → go to DONE; core_insn stays 0.
  - Opcode!=GEMM → set err_opcode, go to DONE.
  - Otherwise → RUN.
- RUN:
  - core_insn = latched instruction; core_start=1 in the first RUN cycle only.
  - Three nested counters, no multiplier:
    - u runs uop_bgn..uop_end-1 (innermost).
    - i runs 0..iter_in-1.
    - o runs 0..iter_out-1.
  - One uop per cycle. uop_idx=u.
  - When u==uop_end-1 && i==iter_in-1 && o==iter_out-1 → DRAIN; the drain counter loads PIPE_DEPTH-1.
  - RUN length is exactly iter_out*iter_in*(uop_end-uop_bgn) cycles.
- DRAIN:
  - core_insn = latched instruction with opcode bits forced to 3'b000 (no new writes are tagged).
  - Decrement per cycle; at 0 → DONE. DRAIN length is PIPE_DEPTH cycles.
- DONE:
  - done=1 for one cycle, then → IDLE.
  - insn_ready=0 in DONE, so back-to-back instructions have a minimum gap of 1 idle cycle.
- busy=1 in RUN and DRAIN only.
- Counter wrap: LOOP_WIDTH counters never wrap, since comparison is against the latched bounds. Maximum values (16383) are legal.
- insn_in is ignored whenever insn_ready=0. The latched instruction is stable from acceptance until DONE.
- err_opcode is cleared only by reset.

Optional Feature:
- Macro GEMM_SCHED_PERF_EN.
- When defined:
  - Adds output perf_cycles [31:0], which counts cycles spent in RUN+DRAIN for the most recent instruction.
  - Cleared on acceptance and frozen at done. Saturates at 32'hFFFFFFFF.
  - Reset value 0.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Single instruction:
  - Stimulus: opcode=010, uop_bgn=0, uop_end=4, iter_out=2, iter_in=3.
  - Required: core_start 1 cycle after acceptance; busy for 24+4=28 cycles; uop_idx sequence 0,1,2,3 repeated 6 times; done pulse once; core_insn=0 afterwards.
- Empty nest:
  - Stimulus: iter_in=0.
  - Required: no core_start, busy never asserts, done 1 cycle after acceptance, core_insn stays 0.
- Back-to-back:
  - Stimulus: insn_valid held high with two instructions (uop_end-uop_bgn=1, iters=1).
  - Required: second acceptance exactly 1 cycle after the first done; each instruction has busy=5 cycles.
- Bad opcode:
  - Stimulus: opcode=011.
  - Required: err_opcode=1 and sticky, done pulse, core_insn stays 0, next GEMM instruction runs normally.
- Reset mid-RUN:
  - Stimulus: rst low on cycle 3 of RUN.
  - Required: core_insn=0, busy=0, done=0 asynchronously; after release, insn_ready=1 and a new instruction runs correctly.
- Max bounds (with GEMM_SCHED_PERF_EN):
  - Stimulus: uop_bgn=8190, uop_end=8192, iter_out=1, iter_in=3.
  - Required: uop_idx 8190,8191 ×3; perf_cycles=10.
